trajectory_engine: RTL and testbench
====================================

Name: trajectory_engine

Overview:
- Parametrised successor to the single-shot trajectory calculator.
- Launches a projectile from (x_pos, 0) with launch velocity (run, rise) and steps it once per clock across a field of width XMAX+1 and height 2^W.
- Supports optional gravity, reflection off the side walls, NTGT simultaneous targets, and a step-count timeout.
- Reports hit/miss, which target was hit, the flight length and the final position to the game controller.

Parameters:
- W, 5: coordinate and velocity magnitude width.
- NTGT, 2: number of targets checked in parallel.
- XMAX, 31: rightmost legal x (wall); must be ≤ 2^W-1.
- G, 1: gravity decrement applied to vertical velocity per step when gravity_en=1.
- MAX_STEPS, 32: flight aborts after this many sampled positions.
- SW, 6: width of steps counter; must satisfy 2^SW > MAX_STEPS.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- shoot  in  1  launch request; sampled only in IDLE.
- x_pos  in  W  launch x.
- rise_in  in  W  initial vertical velocity (unsigned, upward).
- run_in  in  W  horizontal speed.
- direction_in  in  1  0=left, 1=right.
- gravity_en  in  1  enables gravity for this shot (latched at launch).
- target_x  in  NTGT*W  packed target x; target i at bits [i*W +: W].
- target_y  in  NTGT*W  packed target y; live, not latched.
- busy  out  1  high in FLIGHT and DONE.
- result_valid  out  1  one-cycle pulse in DONE.
- hit  out  1  flight ended on a target.
- hit_idx  out  IDXW  index of the target hit; IDXW = max(1, clog2(NTGT)).
- timeout  out  1  flight ended by MAX_STEPS.
- steps  out  SW  index of the last sampled position.
- pos_x  out  W  current/final x.
- pos_y  out  W  current/final y.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: state=IDLE; all outputs 0; internal velocity, direction and gravity latch 0.
- IDLE:
  - shoot=1 → FLIGHT next cycle.
  - Latches pos=(x_pos,0), vx=min(run_in,XMAX), dir=direction_in, vy=+rise_in (signed, W+2 bits), grav=gravity_en.
  - Clears hit, hit_idx, timeout and steps (steps=0).
  - While shoot=0, results from the previous shot are held.
- FLIGHT, evaluated each cycle on the current position, in priority order:
  1. Target compare: any i with pos==(target_x[i],target_y[i]) → DONE, hit=1, hit_idx = lowest matching i. The launch point (step 0) is checked.
  2. Timeout: steps==MAX_STEPS-1 → DONE, timeout=1, hit=0.
  3. Vertical: ny = pos_y + vy (signed). ny<0 or ny>2^W-1 → DONE, miss, position held (not updated).
  4. Otherwise advance: pos_y=ny, steps+=1, vy -= G if grav (saturate at -(2^(W+1))).
- Horizontal step (W+1-bit arithmetic):
  - Right: s=pos_x+vx; if s>XMAX then pos_x=2*XMAX-s and dir=0, else pos_x=s.
  - Left: if vx>pos_x then pos_x=vx-pos_x and dir=1, else pos_x=pos_x-vx.
  - One reflection per step suffices because vx≤XMAX.
- DONE: result_valid=1 for exactly one cycle, then IDLE. shoot in DONE or FLIGHT is ignored (not queued).
- Launch-to-result latency: result_valid asserts (steps+2) cycles after the cycle in which shoot was sampled.
- Target inputs are compared live; changing them mid-flight affects only later compares.
- rst mid-flight: immediate return to IDLE with all outputs 0; no result_valid.

Decomposition:
- Shared package trajectory_pkg holds state encodings (ST_IDLE, ST_FLIGHT, ST_DONE) and the direction constants DIR_LEFT/DIR_RIGHT.
- Sub-module traj_step: combinational next-position/reflection/gravity datapath (inputs pos, vx, dir, vy, grav; outputs npos, ndir, nvy, out_of_field).
- Target compare and priority encoder stay in the top level; all flops use dffr.

Test Plan:
- Straight line, defaults, gravity off: x=4, run=2, rise=3, dir=1, target0=(10,9), target1=(31,31) → positions (4,0),(6,3),(8,6),(10,9); hit=1, hit_idx=0, steps=3, result_valid 5 cycles after shoot.
- Right-wall bounce, gravity off: x=28, run=3, rise=1, dir=1, target0=(28,2) → (28,0),(31,1),(28,2); hit=1, steps=2, internal dir=0.
- Gravity arc: x=0, run=1, rise=3, gravity_en=1, targets at (31,31) → y sequence 0,3,5,6,6,5,3,0, then ny=-4 → miss; hit=0, timeout=0, steps=7, pos=(7,0).
- Priority: target0=target1=(4,0), x=4 → hit at step 0, hit_idx=0, result_valid 2 cycles after shoot; with target0 moved to (9,9), hit_idx=1.
- Timeout: run=0, rise=0, gravity off, no reachable target → timeout=1, hit=0, steps=31, result_valid 33 cycles after shoot.
- Robustness:
  - shoot pulsed during FLIGHT → ignored.
  - rst asserted at step 2 → next cycle IDLE, all outputs 0, no result_valid.
  - New shoot afterwards completes normally.

Source files
------------

// File: rtl/trajectory_pkg.sv
// Shared encodings for the trajectory engine: FSM states and horizontal direction.
package trajectory_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLIGHT = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/dffr.sv
// Plain register with synchronous active-high reset to zero.
// Latency 1 cycle; no flow control.
module dffr #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/traj_step.sv
// Next-position datapath: horizontal move with single wall reflection, vertical move, gravity.
// Purely combinational; no flow control.
module traj_step
  import trajectory_pkg::*;
#(
  parameter int W    = 5,
  parameter int XMAX = 31,
  parameter int G    = 1
) (
  input  logic [W-1:0]        pos_x,
  input  logic [W-1:0]        pos_y,
  input  logic [W-1:0]        vx,
  input  logic                dir,
  input  logic signed [W+1:0] vy,
  input  logic                grav,
  output logic [W-1:0]        npos_x,
  output logic [W-1:0]        npos_y,
  output logic                ndir,
  output logic signed [W+1:0] nvy,
  output logic                out_of_field
);

  localparam int VW = W + 2;
  localparam logic [W:0]          XMAX_W   = (W+1)'(XMAX);
  localparam logic [W:0]          TWO_XMAX = (W+1)'(2 * XMAX);
  localparam logic signed [W+2:0] VY_MIN   = (W+3)'(-(2 ** (W + 1)));

  logic [W:0]          sum_r;
  logic signed [W+2:0] ny;
  logic signed [W+2:0] vy_dec;

  // vx never exceeds XMAX, so at most one reflection is needed per step.
  always_comb begin
    sum_r  = {1'b0, pos_x} + {1'b0, vx};
    npos_x = pos_x;
    ndir   = dir;
    if (dir == DIR_RIGHT) begin
      if (sum_r > XMAX_W) begin
        npos_x = W'(TWO_XMAX - sum_r);
        ndir   = DIR_LEFT;
      end else begin
        npos_x = sum_r[W-1:0];
      end
    end else begin
      if (vx > pos_x) begin
        npos_x = vx - pos_x;
        ndir   = DIR_RIGHT;
      end else begin
        npos_x = pos_x - vx;
      end
    end
  end

  // Any bit at or above W (including the sign) means the new y left the field.
  always_comb begin
    ny           = $signed({3'b000, pos_y}) + $signed({vy[VW-1], vy});
    npos_y       = ny[W-1:0];
    out_of_field = |ny[W+2:W];
  end

  always_comb begin
    vy_dec = $signed({vy[VW-1], vy}) - $signed((W+3)'(G));
    nvy    = vy;
    if (grav) begin
      if (vy_dec < VY_MIN) nvy = VY_MIN[VW-1:0];
      else                 nvy = vy_dec[VW-1:0];
    end
  end

endmodule

// File: rtl/trajectory_engine.sv
// Launches a projectile and steps it once per clock until a target hit, field exit or step timeout.
// Latency steps+2 cycles from sampled shoot to result_valid; no backpressure, shoot ignored while busy.
module trajectory_engine
  import trajectory_pkg::*;
#(
  parameter int  W         = 5,
  parameter int  NTGT      = 2,
  parameter int  XMAX      = 31,
  parameter int  G         = 1,
  parameter int  MAX_STEPS = 32,
  parameter int  SW        = 6,
  localparam int IDXW      = (NTGT > 1) ? $clog2(NTGT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shoot,
  input  logic [W-1:0]      x_pos,
  input  logic [W-1:0]      rise_in,
  input  logic [W-1:0]      run_in,
  input  logic              direction_in,
  input  logic              gravity_en,
  input  logic [NTGT*W-1:0] target_x,
  input  logic [NTGT*W-1:0] target_y,
  output logic              busy,
  output logic              result_valid,
  output logic              hit,
  output logic [IDXW-1:0]   hit_idx,
  output logic              timeout,
  output logic [SW-1:0]     steps,
  output logic [W-1:0]      pos_x,
  output logic [W-1:0]      pos_y
);

  localparam int VW = W + 2;

  state_t              state_q;
  state_t              state_d;
  logic [1:0]          state_raw;

  logic [W-1:0]        pos_x_d;
  logic [W-1:0]        pos_y_d;
  logic [W-1:0]        vx_q;
  logic [W-1:0]        vx_d;
  logic                dir_q;
  logic                dir_d;
  logic signed [VW-1:0] vy_q;
  logic signed [VW-1:0] vy_d;
  logic                grav_q;
  logic                grav_d;
  logic                hit_d;
  logic [IDXW-1:0]     hit_idx_d;
  logic                timeout_d;
  logic [SW-1:0]       steps_d;

  logic [W-1:0]        npos_x;
  logic [W-1:0]        npos_y;
  logic                ndir;
  logic signed [VW-1:0] nvy;
  logic                out_of_field;

  logic                match_any;
  logic [IDXW-1:0]     match_idx;
  logic                at_limit;

  dffr #(.WIDTH(2))    u_state   (.clk(clk), .rst(rst), .d(state_d),   .q(state_raw));
  dffr #(.WIDTH(W))    u_pos_x   (.clk(clk), .rst(rst), .d(pos_x_d),   .q(pos_x));
  dffr #(.WIDTH(W))    u_pos_y   (.clk(clk), .rst(rst), .d(pos_y_d),   .q(pos_y));
  dffr #(.WIDTH(W))    u_vx      (.clk(clk), .rst(rst), .d(vx_d),      .q(vx_q));
  dffr #(.WIDTH(1))    u_dir     (.clk(clk), .rst(rst), .d(dir_d),     .q(dir_q));
  dffr #(.WIDTH(VW))   u_vy      (.clk(clk), .rst(rst), .d(vy_d),      .q(vy_q));
  dffr #(.WIDTH(1))    u_grav    (.clk(clk), .rst(rst), .d(grav_d),    .q(grav_q));
  dffr #(.WIDTH(1))    u_hit     (.clk(clk), .rst(rst), .d(hit_d),     .q(hit));
  dffr #(.WIDTH(IDXW)) u_hit_idx (.clk(clk), .rst(rst), .d(hit_idx_d), .q(hit_idx));
  dffr #(.WIDTH(1))    u_timeout (.clk(clk), .rst(rst), .d(timeout_d), .q(timeout));
  dffr #(.WIDTH(SW))   u_steps   (.clk(clk), .rst(rst), .d(steps_d),   .q(steps));

  assign state_q = state_t'(state_raw);

  traj_step #(.W(W), .XMAX(XMAX), .G(G)) u_step (
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .vx           (vx_q),
    .dir          (dir_q),
    .vy           (vy_q),
    .grav         (grav_q),
    .npos_x       (npos_x),
    .npos_y       (npos_y),
    .ndir         (ndir),
    .nvy          (nvy),
    .out_of_field (out_of_field)
  );

  // Scan from the top so the lowest matching index wins.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int i = NTGT - 1; i >= 0; i--) begin
      if (target_x[i*W +: W] == pos_x && target_y[i*W +: W] == pos_y) begin
        match_any = 1'b1;
        match_idx = IDXW'(i);
      end
    end
  end

  assign at_limit = (steps == SW'(MAX_STEPS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (shoot) state_d = ST_FLIGHT;
      ST_FLIGHT: if (match_any || at_limit || out_of_field) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pos_x_d   = pos_x;
    pos_y_d   = pos_y;
    vx_d      = vx_q;
    dir_d     = dir_q;
    vy_d      = vy_q;
    grav_d    = grav_q;
    hit_d     = hit;
    hit_idx_d = hit_idx;
    timeout_d = timeout;
    steps_d   = steps;
    case (state_q)
      ST_IDLE: begin
        if (shoot) begin
          pos_x_d   = x_pos;
          pos_y_d   = '0;
          vx_d      = (run_in > W'(XMAX)) ? W'(XMAX) : run_in;
          dir_d     = direction_in;
          vy_d      = $signed({2'b00, rise_in});
          grav_d    = gravity_en;
          hit_d     = 1'b0;
          hit_idx_d = '0;
          timeout_d = 1'b0;
          steps_d   = '0;
        end
      end
      ST_FLIGHT: begin
        if (match_any) begin
          hit_d     = 1'b1;
          hit_idx_d = match_idx;
        end else if (at_limit) begin
          timeout_d = 1'b1;
          hit_d     = 1'b0;
        end else if (!out_of_field) begin
          pos_x_d = npos_x;
          pos_y_d = npos_y;
          dir_d   = ndir;
          vy_d    = nvy;
          steps_d = steps + SW'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy         = (state_q != ST_IDLE);
    result_valid = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_trajectory_engine.sv
// Scenario bench for trajectory_engine: expected results queued at launch, compared when result_valid fires.
module tb_trajectory_engine;

  localparam int W    = 5;
  localparam int NTGT = 2;
  localparam int SW   = 6;
  localparam int IDXW = 1;

  typedef struct packed {
    logic            hit;
    logic [IDXW-1:0] idx;
    logic            timeout;
    logic [SW-1:0]   steps;
    logic [W-1:0]    x;
    logic [W-1:0]    y;
  } res_t;

  typedef struct {
    res_t r;
    int   lat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              shoot = 1'b0;
  logic [W-1:0]      x_pos = '0;
  logic [W-1:0]      rise_in = '0;
  logic [W-1:0]      run_in = '0;
  logic              direction_in = 1'b0;
  logic              gravity_en = 1'b0;
  logic [NTGT*W-1:0] target_x = '0;
  logic [NTGT*W-1:0] target_y = '0;
  logic              busy;
  logic              result_valid;
  logic              hit;
  logic [IDXW-1:0]   hit_idx;
  logic              timeout;
  logic [SW-1:0]     steps;
  logic [W-1:0]      pos_x;
  logic [W-1:0]      pos_y;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [2*W-1:0] trace_q[$];

  always #5 clk = ~clk;

  trajectory_engine #(
    .W(W), .NTGT(NTGT), .XMAX(31), .G(1), .MAX_STEPS(32), .SW(SW)
  ) dut (
    .clk(clk), .rst(rst), .shoot(shoot), .x_pos(x_pos), .rise_in(rise_in),
    .run_in(run_in), .direction_in(direction_in), .gravity_en(gravity_en),
    .target_x(target_x), .target_y(target_y), .busy(busy),
    .result_valid(result_valid), .hit(hit), .hit_idx(hit_idx),
    .timeout(timeout), .steps(steps), .pos_x(pos_x), .pos_y(pos_y)
  );

  function automatic res_t mk(input logic h, input logic [IDXW-1:0] i, input logic t,
                              input int s, input int x, input int y);
    res_t r;
    r.hit = h; r.idx = i; r.timeout = t;
    r.steps = SW'(s); r.x = W'(x); r.y = W'(y);
    return r;
  endfunction

  function automatic void push_exp(input res_t r, input int lat);
    exp_t e;
    e.r = r;
    e.lat = lat;
    sb.push_back(e);
  endfunction

  // Launch from a negedge, record in-flight positions, return at the first IDLE negedge after DONE.
  task automatic run_shot(input int x, input int run, input int rise, input logic d, input logic g,
                          input int pulse_at, input int budget, output res_t o, output int lat);
    trace_q.delete();
    x_pos = W'(x); run_in = W'(run); rise_in = W'(rise);
    direction_in = d; gravity_en = g;
    shoot = 1'b1;
    lat = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      shoot = (c == pulse_at);
      if (result_valid) begin
        lat = c;
        break;
      end
      if (busy) trace_q.push_back({pos_x, pos_y});
    end
    o = {hit, hit_idx, timeout, steps, pos_x, pos_y};
    @(negedge clk);
    shoot = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, result_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got %b required 00", {busy, result_valid});
    end
    checks++;
    if ({hit, hit_idx, timeout, steps, pos_x, pos_y} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h required 0", {hit, hit_idx, timeout, steps, pos_x, pos_y});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b required 0", busy); end
  endtask

  task automatic test_straight();
    res_t o; int lat; exp_t e;
    logic [2*W-1:0] tr[4];
    tr = '{{5'd4, 5'd0}, {5'd6, 5'd3}, {5'd8, 5'd6}, {5'd10, 5'd9}};
    target_x = {5'd31, 5'd10}; target_y = {5'd31, 5'd9};
    push_exp(mk(1, 0, 0, 3, 10, 9), 5);
    run_shot(4, 2, 3, 1'b1, 1'b0, -1, 40, o, lat);
    e = sb.pop_front();
    checks++;
    if (o !== e.r) begin errors++; $display("FAIL straight_result: got %h required %h", o, e.r); end
    checks++;
    if (lat !== e.lat) begin errors++; $display("FAIL straight_latency: got %0d required %0d", lat, e.lat); end
    checks++;
    if (trace_q.size() != 4) begin
      errors++; $display("FAIL straight_trace_len: got %0d required 4", trace_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (trace_q[i] !== tr[i]) begin
          errors++; $display("FAIL straight_trace[%0d]: got %h required %h", i, trace_q[i], tr[i]);
        end
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({hit, hit_idx, timeout, steps, pos_x, pos_y} !== e.r || busy !== 1'b0) begin
      errors++; $display("FAIL straight_hold: got %h busy=%b required %h busy=0",
                         {hit, hit_idx, timeout, steps, pos_x, pos_y}, busy, e.r);
    end
  endtask

  task automatic test_bounce();
    res_t o; int lat; exp_t e;
    target_x = {5'd31, 5'd28}; target_y = {5'd31, 5'd2};
    push_exp(mk(1, 0, 0, 2, 28, 2), 4);
    run_shot(28, 3, 1, 1'b1, 1'b0, -1, 40, o, lat);
    e = sb.pop_front();
    checks++;
    if (o !== e.r) begin errors++; $display("FAIL bounce_result: got %h required %h", o, e.r); end
    checks++;
    if (lat !== e.lat) begin errors++; $display("FAIL bounce_latency: got %0d required %0d", lat, e.lat); end
    checks++;
    if (dut.dir_q !== 1'b0) begin errors++; $display("FAIL bounce_dir: got %b required 0", dut.dir_q); end
    checks++;
    if (trace_q.size() != 3 || trace_q[1] !== {5'd31, 5'd1}) begin
      errors++; $display("FAIL bounce_wall_pos: got %0d entries required 3 with step1=(31,1)", trace_q.size());
    end
  endtask

  task automatic test_gravity();
    res_t o; int lat; exp_t e;
    int ys[8];
    ys = '{0, 3, 5, 6, 6, 5, 3, 0};
    target_x = {5'd31, 5'd31}; target_y = {5'd31, 5'd31};
    push_exp(mk(0, 0, 0, 7, 7, 0), 9);
    run_shot(0, 1, 3, 1'b1, 1'b1, -1, 40, o, lat);
    e = sb.pop_front();
    checks++;
    if (o !== e.r) begin errors++; $display("FAIL gravity_result: got %h required %h", o, e.r); end
    checks++;
    if (lat !== e.lat) begin errors++; $display("FAIL gravity_latency: got %0d required %0d", lat, e.lat); end
    checks++;
    if (trace_q.size() != 8) begin
      errors++; $display("FAIL gravity_trace_len: got %0d required 8", trace_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (trace_q[i] !== {W'(i), W'(ys[i])}) begin
          errors++; $display("FAIL gravity_trace[%0d]: got %h required %h", i, trace_q[i], {W'(i), W'(ys[i])});
        end
      end
    end
  endtask

  task automatic test_priority();
    res_t o; int lat; exp_t e;
    target_x = {5'd4, 5'd4}; target_y = {5'd0, 5'd0};
    push_exp(mk(1, 0, 0, 0, 4, 0), 2);
    run_shot(4, 2, 3, 1'b1, 1'b0, -1, 40, o, lat);
    e = sb.pop_front();
    checks++;
    if (o !== e.r) begin errors++; $display("FAIL prio_both_result: got %h required %h", o, e.r); end
    checks++;
    if (lat !== e.lat) begin errors++; $display("FAIL prio_both_latency: got %0d required %0d", lat, e.lat); end
    target_x = {5'd4, 5'd9}; target_y = {5'd0, 5'd9};
    push_exp(mk(1, 1, 0, 0, 4, 0), 2);
    run_shot(4, 2, 3, 1'b1, 1'b0, -1, 40, o, lat);
    e = sb.pop_front();
    checks++;
    if (o !== e.r) begin errors++; $display("FAIL prio_t1_result: got %h required %h", o, e.r); end
    checks++;
    if (lat !== e.lat) begin errors++; $display("FAIL prio_t1_latency: got %0d required %0d", lat, e.lat); end
  endtask

  task automatic test_timeout();
    res_t o; int lat; exp_t e;
    target_x = {5'd31, 5'd30}; target_y = {5'd31, 5'd30};
    push_exp(mk(0, 0, 1, 31, 5, 0), 33);
    run_shot(5, 0, 0, 1'b1, 1'b0, -1, 60, o, lat);
    e = sb.pop_front();
    checks++;
    if (o !== e.r) begin errors++; $display("FAIL timeout_result: got %h required %h", o, e.r); end
    checks++;
    if (lat !== e.lat) begin errors++; $display("FAIL timeout_latency: got %0d required %0d", lat, e.lat); end
  endtask

  task automatic test_robust();
    res_t o; int lat; exp_t e; int stray;
    target_x = {5'd31, 5'd10}; target_y = {5'd31, 5'd9};
    // shoot during FLIGHT, then during DONE: neither may start another flight
    push_exp(mk(1, 0, 0, 3, 10, 9), 5);
    run_shot(4, 2, 3, 1'b1, 1'b0, 2, 40, o, lat);
    e = sb.pop_front();
    checks++;
    if (o !== e.r || lat !== e.lat) begin
      errors++; $display("FAIL shoot_in_flight: got %h lat %0d required %h lat %0d", o, lat, e.r, e.lat);
    end
    push_exp(mk(1, 0, 0, 3, 10, 9), 5);
    run_shot(4, 2, 3, 1'b1, 1'b0, 5, 40, o, lat);
    e = sb.pop_front();
    stray = 0;
    repeat (4) begin @(negedge clk); if (busy) stray++; end
    checks++;
    if (o !== e.r || lat !== e.lat || stray != 0) begin
      errors++; $display("FAIL shoot_in_done: got %h lat %0d busy %0d required %h lat %0d busy 0",
                         o, lat, stray, e.r, e.lat);
    end
    // reset at step 2
    x_pos = 5'd4; run_in = 5'd2; rise_in = 5'd3; direction_in = 1'b1; gravity_en = 1'b0;
    shoot = 1'b1;
    @(negedge clk); shoot = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({pos_x, pos_y, steps} !== {5'd8, 5'd6, 6'd2} || busy !== 1'b1) begin
      errors++; $display("FAIL pre_rst_step2: got (%0d,%0d) steps %0d busy %b required (8,6) steps 2 busy 1",
                         pos_x, pos_y, steps, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, result_valid, hit, hit_idx, timeout, steps, pos_x, pos_y} !== '0) begin
      errors++; $display("FAIL rst_mid_flight: got %h required 0",
                         {busy, result_valid, hit, hit_idx, timeout, steps, pos_x, pos_y});
    end
    rst = 1'b0;
    stray = 0;
    repeat (8) begin @(negedge clk); if (result_valid || busy) stray++; end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL rst_no_result: got %0d active cycles required 0", stray); end
    push_exp(mk(1, 0, 0, 3, 10, 9), 5);
    run_shot(4, 2, 3, 1'b1, 1'b0, -1, 40, o, lat);
    e = sb.pop_front();
    checks++;
    if (o !== e.r || lat !== e.lat) begin
      errors++; $display("FAIL shot_after_rst: got %h lat %0d required %h lat %0d", o, lat, e.r, e.lat);
    end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_bounce();
    test_gravity();
    test_priority();
    test_timeout();
    test_robust();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
